// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for the multicycle RV32I core.
// Sequences fetch/decode/execute/memory/writeback and drives the shared-memory
// datapath mux selects and write strobes. It also provides a memory-ready
// handshake, an illegal-opcode trap and a retired-instruction counter.
module multicycle_ctrl_fsm #(
  parameter int unsigned EN_JALR     = 1,
  parameter int unsigned EN_LUI      = 1,
  parameter int unsigned MEM_HS      = 1,
  parameter int unsigned TRAP_STICKY = 1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic             mem_ready,
  output logic             PCUpdate,
  output logic             Branch,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             AdrSrc,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [2:0]       ImmSrc,
  output logic             illegal_op,
  output logic             instr_retire,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [3:0]       state_o
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    JALR     = 4'd11,
    LUI      = 4'd12,
    TRAP     = 4'd15
  } state_t;

  state_t state;
  state_t next;
  logic   mr;

  // Without the handshake, every memory access completes in one cycle.
  assign mr      = (MEM_HS != 0) ? mem_ready : 1'b1;
  assign state_o = state;

  // State register with asynchronous return to FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= next;
  end

  // Next-state selection from the current state, opcode and memory readiness.
  always_comb begin
    next = state;
    case (state)
      FETCH:    next = mr ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next = MEMADR;
          OP_R:         next = EXECR;
          OP_I:         next = EXECI;
          OP_BEQ:       next = BEQ;
          OP_JAL:       next = JAL;
          OP_JALR:      next = (EN_JALR != 0) ? JALR : TRAP;
          OP_LUI:       next = (EN_LUI != 0) ? LUI : TRAP;
          default:      next = TRAP;
        endcase
      end
      MEMADR:   next = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  next = mr ? MEMWB : MEMREAD;
      MEMWB:    next = FETCH;
      MEMWRITE: next = mr ? FETCH : MEMWRITE;
      EXECR:    next = ALUWB;
      EXECI:    next = ALUWB;
      ALUWB:    next = FETCH;
      BEQ:      next = FETCH;
      JAL:      next = ALUWB;
      JALR:     next = JAL;
      LUI:      next = ALUWB;
      TRAP:     next = (TRAP_STICKY != 0) ? TRAP : FETCH;
      default:  next = FETCH;
    endcase
  end

  // Moore control decode. Exceptions: the FETCH strobes follow mem_ready,
  // and retire marks the last cycle of a completing instruction.
  // All outputs are held low while reset is asserted.
  always_comb begin
    PCUpdate     = 1'b0;
    Branch       = 1'b0;
    RegWrite     = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    AdrSrc       = 1'b0;
    ResultSrc    = '0;
    ALUSrcA      = '0;
    ALUSrcB      = '0;
    ALUOp        = '0;
    illegal_op   = 1'b0;
    instr_retire = 1'b0;
    case (state)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mr;
        PCUpdate  = mr;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc    = 2'b01;
        RegWrite     = 1'b1;
        instr_retire = (next == FETCH);
      end
      MEMWRITE: begin
        AdrSrc       = 1'b1;
        MemWrite     = 1'b1;
        instr_retire = mr && (next == FETCH);
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      ALUWB: begin
        RegWrite     = 1'b1;
        instr_retire = (next == FETCH);
      end
      BEQ: begin
        ALUSrcA      = 2'b10;
        ALUOp        = 2'b01;
        Branch       = 1'b1;
        instr_retire = (next == FETCH);
      end
      JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        PCUpdate = 1'b1;
      end
      JALR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
      end
      TRAP:    illegal_op = 1'b1;
      default: ;
    endcase
    if (!rst_n) begin
      PCUpdate     = 1'b0;
      Branch       = 1'b0;
      RegWrite     = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      AdrSrc       = 1'b0;
      ResultSrc    = '0;
      ALUSrcA      = '0;
      ALUSrcB      = '0;
      ALUOp        = '0;
      illegal_op   = 1'b0;
      instr_retire = 1'b0;
    end
  end

  // Immediate format select, decoded directly from the opcode.
  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      OP_SW:   ImmSrc = 3'b001;
      OP_BEQ:  ImmSrc = 3'b010;
      OP_JAL:  ImmSrc = 3'b011;
      OP_LUI:  ImmSrc = 3'b100;
      default: ImmSrc = 3'b000;
    endcase
    if (!rst_n) ImmSrc = 3'b000;
  end

  // Retired-instruction counter, wrapping at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            retired_cnt <= '0;
    else if (instr_retire) retired_cnt <= retired_cnt + CNT_W'(1);
  end

endmodule
